// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: 1 start, 8 data bits LSB-first, 1 stop bit.
// Ports: clk, rstn (sync, active-high), data[7:0], start -> ready, tx.
module uart_tx_8n1 #(
  parameter int BAUD = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data,
  input  logic       start,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (BAUD > 2) ? $clog2(BAUD) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          bit_end;
  logic [2:0]    idx_nx;

  assign bit_end = (cnt == LAST);
  assign idx_nx  = idx + 3'd1;

  // tx and ready are registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
      ready <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx    <= 1'b1;
          ready <= 1'b1;
          cnt   <= '0;
          if (start) begin
            shift <= data;
            state <= S_START;
            tx    <= 1'b0;
            ready <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            state <= S_DATA;
            tx    <= shift[0];
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              idx <= idx_nx;
              tx  <= shift[idx_nx];
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= S_IDLE;
            tx    <= 1'b1;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          // unused encodings fall back to a quiet idle line
          state <= S_IDLE;
          cnt   <= '0;
          idx   <= '0;
          tx    <= 1'b1;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Self-checking bench for uart_tx_8n1.
// Fast instance (BAUD=4) plus slow instance (BAUD=434).
module tb_uart_tx_8n1;

  localparam int B  = 4;
  localparam int BS = 434;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] data;
  logic       start;
  logic       ready;
  logic       tx;
  logic [7:0] data_s;
  logic       start_s;
  logic       ready_s;
  logic       tx_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_8n1 #(.BAUD(B)) u_fast (
    .clk   (clk),
    .rstn  (rstn),
    .data  (data),
    .start (start),
    .ready (ready),
    .tx    (tx)
  );

  uart_tx_8n1 #(.BAUD(BS)) u_slow (
    .clk   (clk),
    .rstn  (rstn),
    .data  (data_s),
    .start (start_s),
    .ready (ready_s),
    .tx    (tx_s)
  );

  typedef struct {
    logic [7:0] d;
    logic [9:0] exp;
    bit         hold;
    int         chg_k;
    logic [7:0] chg_d;
  } vec_t;

  vec_t tbl[6];

  // Reference: line bits in transmit order, index 0 = start bit.
  function automatic logic [9:0] line_bits(input logic [7:0] d);
    logic [9:0] b;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    b[9] = 1'b1;
    return b;
  endfunction

  task automatic chk(input string name, input int k,
                     input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s k=%0d got %b want %b", name, k, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the
  // negedge of the first idle cycle after the frame.
  task automatic frame(input logic [7:0] d, input logic [9:0] exp,
                       input bit hold, input int chg_k,
                       input logic [7:0] chg_d);
    chk("pre_ready", -1, ready, 1'b1);
    data  = d;
    start = 1'b1;
    for (int k = 0; k < 10*B; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) start = 1'b0;
      chk("tx", k, tx, exp[k/B]);
      chk("ready_lo", k, ready, 1'b0);
      if (k == chg_k) data = chg_d;
    end
    @(negedge clk);
    chk("ready_back", 10*B, ready, 1'b1);
    chk("tx_idle", 10*B, tx, 1'b1);
  endtask

  initial begin
    logic [9:0] eb;
    logic [7:0] rd;
    int n;

    tbl[0] = '{8'h55, 10'b1010101010, 1'b0, -1, 8'h00};
    tbl[1] = '{8'h0A, 10'b1000010100, 1'b0, 15, 8'hFF};
    tbl[2] = '{8'h41, 10'b1010000010, 1'b1, -1, 8'h00};
    tbl[3] = '{8'h0A, 10'b1000010100, 1'b0, -1, 8'h00};
    tbl[4] = '{8'hFF, 10'b1111111110, 1'b0, 7,  8'h00};
    tbl[5] = '{8'h00, 10'b1000000000, 1'b0, -1, 8'h00};

    rstn    = 1'b1;
    start   = 1'b0;
    data    = 8'h00;
    start_s = 1'b0;
    data_s  = 8'h00;

    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", 0, tx, 1'b1);
      chk("rst_ready", 0, ready, 1'b1);
      chk("rst_tx_s", 0, tx_s, 1'b1);
    end
    rstn = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_tx", 0, tx, 1'b1);
      chk("idle_ready", 0, ready, 1'b1);
    end

    // tbl[2] holds start so tbl[3] follows after one idle cycle
    foreach (tbl[i])
      frame(tbl[i].d, tbl[i].exp, tbl[i].hold,
            tbl[i].chg_k, tbl[i].chg_d);

    // reset in the middle of a frame
    @(negedge clk);
    eb = line_bits(8'h96);
    data  = 8'h96;
    start = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("abort_tx", k, tx, eb[k/B]);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_tx_hi", 0, tx, 1'b1);
    chk("abort_ready", 0, ready, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    chk("post_abort_tx", 0, tx, 1'b1);
    chk("post_abort_rdy", 0, ready, 1'b1);
    frame(8'hC3, 10'b1110000110, 1'b0, -1, 8'h00);

    // random bytes, random idle gaps
    for (int r = 0; r < 12; r++) begin
      rd = 8'($urandom);
      n  = $urandom_range(0, 3);
      repeat (n) begin
        @(negedge clk);
        chk("gap_tx", 0, tx, 1'b1);
        chk("gap_ready", 0, ready, 1'b1);
      end
      frame(rd, line_bits(rd), 1'b0, $urandom_range(0, 39),
            8'($urandom));
    end

    // slow instance: full-rate bit timing
    @(negedge clk);
    chk("slow_pre", 0, ready_s, 1'b1);
    eb = line_bits(8'h0A);
    data_s  = 8'h0A;
    start_s = 1'b1;
    n = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (ready_s) break;
      if (k % 31 == 0 || k % BS == 0 || k % BS == BS - 1)
        chk("slow_tx", k, tx_s, eb[k/BS]);
      n++;
    end
    vectors++;
    if (n != 10*BS) begin
      miscompares++;
      $display("FAIL slow_len got %0d want %0d", n, 10*BS);
    end
    chk("slow_tx_idle", n, tx_s, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
